fpnew_slice_share_arb: RTL and testbench

Round-robin arbiter that shares one format-slice execution unit (FMA, noncomp or similar in-order pipeline) between `NumReq` independent issue ports. It selects one request per cycle and records the winner's index in an in-flight ID FIFO. Because the slice completes in order, each result is routed back to the requester that issued it. It sits between the per-port issue logic and a single opgroup format slice.

---
 rtl/fpnew_slice_share_arb.sv | 205 ++++++++++++++++++++
 tb/tb_fpnew_slice_share_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_slice_share_arb.sv
// fpnew_pkg (minimal) + fpnew_slice_share_arb
//
// Shares one in-order format slice between NumReq issue ports. A round-robin
// arbiter picks one request per cycle. Each issued op pushes its port index
// into an in-flight ID FIFO. Because the slice completes in order, the FIFO
// head names the port that owns the next result.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              kill all in-flight work (mirrored on slc_flush_o)
//   req_*                per-port issue handshake and fields (packed per port)
//   slc_*_o / slc_ready_i        slice input side (selected request)
//   slc_out_* / slc_result_i ... slice output side
//   rsp_valid_o/rsp_ready_i      per-port response handshake
//   rsp_result/status/tag_o      shared response data
//   busy_o               ID FIFO non-empty

package fpnew_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

// Per-port decode: issue ready and response valid for one requester.
module fpnew_slice_share_arb_lane (
  input  logic win_i,        // this port is the current winner
  input  logic can_issue_i,
  input  logic slc_ready_i,
  input  logic head_i,       // this port owns the FIFO head
  input  logic rsp_ok_i,     // a response may be presented this cycle
  output logic req_ready_o,
  output logic rsp_valid_o
);
  assign req_ready_o = win_i & can_issue_i & slc_ready_i;
  assign rsp_valid_o = head_i & rsp_ok_i;
endmodule

module fpnew_slice_share_arb #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned Width       = 32,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned MaxInFlight = 4,
  parameter int unsigned TagWidth    = 8
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             flush_i,
  input  logic [NumReq-1:0]                                req_valid_i,
  output logic [NumReq-1:0]                                req_ready_o,
  input  logic [NumReq-1:0][NumOperands-1:0][Width-1:0]    req_operands_i,
  input  fpnew_pkg::operation_e [NumReq-1:0]               req_op_i,
  input  fpnew_pkg::roundmode_e [NumReq-1:0]               req_rnd_i,
  input  logic [NumReq-1:0][TagWidth-1:0]                  req_tag_i,
  output logic                                             slc_valid_o,
  input  logic                                             slc_ready_i,
  output logic [NumOperands-1:0][Width-1:0]                slc_operands_o,
  output fpnew_pkg::operation_e                            slc_op_o,
  output fpnew_pkg::roundmode_e                            slc_rnd_o,
  output logic [TagWidth-1:0]                              slc_tag_o,
  output logic                                             slc_flush_o,
  input  logic                                             slc_out_valid_i,
  output logic                                             slc_out_ready_o,
  input  logic [Width-1:0]                                 slc_result_i,
  input  fpnew_pkg::status_t                               slc_status_i,
  input  logic [TagWidth-1:0]                              slc_tag_i,
  output logic [NumReq-1:0]                                rsp_valid_o,
  input  logic [NumReq-1:0]                                rsp_ready_i,
  output logic [Width-1:0]                                 rsp_result_o,
  output fpnew_pkg::status_t                               rsp_status_o,
  output logic [TagWidth-1:0]                              rsp_tag_o,
  output logic                                             busy_o
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
  localparam int unsigned CntW = $clog2(MaxInFlight + 1);

  logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, winner, cand, head;
  logic            lock_q, lock_d, found;
  logic [MaxInFlight-1:0][IdxW-1:0] fifo_q;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            empty, full, pop, push, can_issue, rsp_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxInFlight - 1)) ? '0 : p + 1'b1;
  endfunction

  // Cyclic search starting at rr_q; a stalled offer stays locked until taken
  // so the slice never sees its input change under backpressure.
  always_comb begin
    winner = rr_q;
    cand   = '0;
    found  = 1'b0;
    if (lock_q) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = IdxW'((32'(rr_q) + k) % NumReq);
        if (!found && req_valid_i[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  assign head  = fifo_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(MaxInFlight));

  // With nothing tracked, stray slice outputs are drained.
  assign slc_out_ready_o = flush_i | empty | rsp_ready_i[head];
  assign pop             = slc_out_valid_i & slc_out_ready_o & ~empty;
  assign can_issue       = ~flush_i & (~full | pop);
  assign slc_valid_o     = can_issue & req_valid_i[winner];
  assign push            = slc_valid_o & slc_ready_i;
  assign rsp_ok          = slc_out_valid_i & ~empty & ~flush_i;

  assign slc_operands_o = req_operands_i[winner];
  assign slc_op_o       = req_op_i[winner];
  assign slc_rnd_o      = req_rnd_i[winner];
  assign slc_tag_o      = req_tag_i[winner];
  assign slc_flush_o    = flush_i;

  assign rsp_result_o = slc_result_i;
  assign rsp_status_o = slc_status_i;
  assign rsp_tag_o    = slc_tag_i;
  assign busy_o       = ~empty;

  for (genvar g = 0; g < NumReq; g++) begin : g_lane
    fpnew_slice_share_arb_lane u_lane (
      .win_i       (winner == IdxW'(g)),
      .can_issue_i (can_issue),
      .slc_ready_i (slc_ready_i),
      .head_i      (head == IdxW'(g)),
      .rsp_ok_i    (rsp_ok),
      .req_ready_o (req_ready_o[g]),
      .rsp_valid_o (rsp_valid_o[g])
    );
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      rr_d   = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
      lock_d = 1'b0;
      wptr_d = ptr_inc(wptr_q);
    end else if (slc_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // rr_q survives a flush so fairness carries across it.
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      fifo_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      if (push) fifo_q[wptr_q] <= winner;
    end
  end
endmodule

// File: tb/tb_fpnew_slice_share_arb.sv
// Bench for fpnew_slice_share_arb: requester queues, an in-order slice model
// with configurable latency, and a port-order reference model for the
// randomized run.
module tb_fpnew_slice_share_arb;
  localparam int NR = 4, W = 32, NO = 3, MF = 4, TW = 8;

  typedef struct {
    logic [NO-1:0][W-1:0]  ops;
    fpnew_pkg::operation_e op;
    fpnew_pkg::roundmode_e rnd;
    logic [TW-1:0]         tag;
  } req_t;
  typedef struct { logic [TW-1:0] tag; logic [W-1:0] res; int due; } sl_t;
  typedef struct { int port; logic [TW-1:0] tag; logic [W-1:0] res; logic [4:0] st; int cyc; } rsp_t;

  logic clk = 1'b0, rst_n, flush;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR-1:0][NO-1:0][W-1:0] req_operands;
  fpnew_pkg::operation_e [NR-1:0] req_op;
  fpnew_pkg::roundmode_e [NR-1:0] req_rnd;
  logic [NR-1:0][TW-1:0] req_tag;
  logic slc_valid, slc_ready, slc_flush, so_valid, so_ready;
  logic [NO-1:0][W-1:0] slc_operands;
  fpnew_pkg::operation_e slc_op;
  fpnew_pkg::roundmode_e slc_rnd;
  logic [TW-1:0] slc_tag, so_tag, rsp_tag;
  logic [W-1:0] so_result, rsp_result;
  fpnew_pkg::status_t so_status, rsp_status;
  logic [NR-1:0] rsp_valid, rsp_ready;
  logic busy;

  fpnew_slice_share_arb #(.NumReq(NR), .Width(W), .NumOperands(NO), .MaxInFlight(MF), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_op_i(req_op), .req_rnd_i(req_rnd), .req_tag_i(req_tag),
    .slc_valid_o(slc_valid), .slc_ready_i(slc_ready), .slc_operands_o(slc_operands),
    .slc_op_o(slc_op), .slc_rnd_o(slc_rnd), .slc_tag_o(slc_tag), .slc_flush_o(slc_flush),
    .slc_out_valid_i(so_valid), .slc_out_ready_o(so_ready), .slc_result_i(so_result),
    .slc_status_i(so_status), .slc_tag_i(so_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag), .busy_o(busy)
  );

  always #5 clk = ~clk;

  req_t rq[NR][$];
  sl_t  sq[$];
  int   grant_log[$], grant_cyc[$];
  rsp_t rsp_log[$];
  logic [W-1:0] exp_res[logic [TW-1:0]];
  int   cyc = 0, lat = 1;
  logic stray = 1'b0;
  int   total = 0, bad = 0;

  function automatic logic [W-1:0] res_of(input logic [NO-1:0][W-1:0] ops,
                                          input fpnew_pkg::operation_e op,
                                          input fpnew_pkg::roundmode_e rnd);
    return ops[0] ^ ops[1] ^ ops[2] ^ 32'({op, rnd});
  endfunction

  task automatic add_req(input int p, input logic [TW-1:0] tag);
    req_t r;
    for (int j = 0; j < NO; j++) r.ops[j] = $urandom;
    r.op  = fpnew_pkg::operation_e'($urandom_range(0, 14));
    r.rnd = fpnew_pkg::roundmode_e'($urandom_range(0, 4));
    r.tag = tag;
    exp_res[tag] = res_of(r.ops, r.op, r.rnd);
    rq[p].push_back(r);
  endtask

  // Called at the falling edge: present requester and slice-output state, settle.
  task automatic drive();
    for (int p = 0; p < NR; p++) begin
      req_valid[p] = (rq[p].size() > 0);
      if (rq[p].size() > 0) begin
        req_operands[p] = rq[p][0].ops;
        req_op[p]       = rq[p][0].op;
        req_rnd[p]      = rq[p][0].rnd;
        req_tag[p]      = rq[p][0].tag;
      end
    end
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      so_valid  = 1'b1;
      so_result = sq[0].res;
      so_tag    = sq[0].tag;
      so_status = fpnew_pkg::status_t'(sq[0].tag[4:0]);
    end else begin
      so_valid  = stray;
      so_result = $urandom;
      so_tag    = 8'hEE;
      so_status = '0;
    end
    #1;
  endtask

  // Record handshakes, advance the clock, update the environment models.
  task automatic edge_step();
    int gp, last;
    sl_t s;
    rsp_t r;
    bit took_slice;
    gp = -1;
    for (int p = 0; p < NR; p++) if (req_ready[p] && req_valid[p]) gp = p;
    if (slc_valid && slc_ready) begin
      s.tag = slc_tag;
      s.res = res_of(slc_operands, slc_op, slc_rnd);
      s.due = cyc + lat;
      last = (sq.size() > 0) ? sq[$].due : 0;
      if (s.due < last) s.due = last;
      sq.push_back(s);
      grant_log.push_back(gp);
      grant_cyc.push_back(cyc);
    end
    for (int p = 0; p < NR; p++) if (rsp_valid[p] && rsp_ready[p]) begin
      r.port = p; r.tag = rsp_tag; r.res = rsp_result; r.st = rsp_status; r.cyc = cyc;
      rsp_log.push_back(r);
    end
    took_slice = so_valid && so_ready && sq.size() > 0 && sq[0].due <= cyc;
    @(posedge clk);
    cyc++;
    if (gp >= 0) void'(rq[gp].pop_front());
    if (took_slice) void'(sq.pop_front());
    if (flush) sq.delete();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin drive(); edge_step(); end
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; slc_ready = 1'b1; rsp_ready = '1; stray = 1'b0; lat = 1;
    for (int p = 0; p < NR; p++) rq[p].delete();
    sq.delete();
    clear_logs();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_rsp(input int n, input int bound, input string nm);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < bound) begin drive(); edge_step(); k++; end
    total++;
    if (rsp_log.size() < n) begin
      bad++; $display("FAIL %s_timeout got=%0d responses want=%0d", nm, rsp_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; slc_ready = 1'b0; rsp_ready = '1; stray = 1'b0;
    drive();
    total++; if (slc_valid !== 1'b0) begin bad++; $display("FAIL rst_slc_valid got=%0b want=0", slc_valid); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (so_ready !== 1'b1) begin bad++; $display("FAIL rst_out_ready got=%0b want=1", so_ready); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%0b want=0000", req_ready); end
    slc_ready = 1'b1; stray = 1'b1;
    drive();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_req_ready_win got=%0b want=0001", req_ready); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rst_stray_rsp got=%0b want=0", rsp_valid); end
    total++; if (so_ready !== 1'b1) begin bad++; $display("FAIL rst_stray_ready got=%0b want=1", so_ready); end
    stray = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    do_reset();
    lat = 2;
    for (int i = 0; i < 3; i++) add_req(2, 8'(8'h10 + i));
    run_until_rsp(3, 30, "single");
    total++; if (grant_log.size() != 3) begin bad++; $display("FAIL single_grants got=%0d want=3", grant_log.size()); end
    for (int i = 0; i < grant_log.size() && i < 3; i++) begin
      total++; if (grant_log[i] != 2) begin bad++; $display("FAIL single_grant_port got=%0d want=2", grant_log[i]); end
      total++; if (grant_cyc[i] != grant_cyc[0] + i) begin bad++; $display("FAIL single_b2b got=%0d want=%0d", grant_cyc[i], grant_cyc[0] + i); end
    end
    for (int i = 0; i < rsp_log.size() && i < 3; i++) begin
      total++; if (rsp_log[i].port != 2) begin bad++; $display("FAIL single_rsp_port got=%0d want=2", rsp_log[i].port); end
      total++; if (rsp_log[i].tag !== 8'(8'h10 + i)) begin bad++; $display("FAIL single_rsp_tag got=%0h want=%0h", rsp_log[i].tag, 8'h10 + i); end
      total++; if (rsp_log[i].res !== exp_res[rsp_log[i].tag]) begin bad++; $display("FAIL single_rsp_res got=%0h want=%0h", rsp_log[i].res, exp_res[rsp_log[i].tag]); end
      total++; if (rsp_log[i].st !== rsp_log[i].tag[4:0]) begin bad++; $display("FAIL single_rsp_status got=%0h want=%0h", rsp_log[i].st, rsp_log[i].tag[4:0]); end
    end
    drive();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle got=%0b want=0", busy); end
  endtask

  task automatic test_fairness();
    do_reset();
    lat = 1;
    for (int k = 0; k < 8; k++) for (int p = 0; p < NR; p++) add_req(p, 8'((p << 6) | k));
    run_until_rsp(32, 200, "fair");
    total++; if (grant_log.size() != 32) begin bad++; $display("FAIL fair_grants got=%0d want=32", grant_log.size()); end
    for (int i = 0; i < grant_log.size(); i++) begin
      total++; if (grant_log[i] != i % NR) begin bad++; $display("FAIL fair_order idx=%0d got=%0d want=%0d", i, grant_log[i], i % NR); end
    end
    for (int i = 0; i < rsp_log.size(); i++) begin
      total++; if (rsp_log[i].tag !== 8'(((i % NR) << 6) | (i / NR)) || rsp_log[i].port != i % NR) begin
        bad++; $display("FAIL fair_rsp idx=%0d got=%0d/%0h want=%0d/%0h", i, rsp_log[i].port, rsp_log[i].tag, i % NR, ((i % NR) << 6) | (i / NR));
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    lat = 1; slc_ready = 1'b0;
    add_req(1, 8'h21);
    for (int c = 0; c < 3; c++) begin
      drive();
      total++; if (slc_valid !== 1'b1 || slc_tag !== 8'h21) begin bad++; $display("FAIL lock_hold c=%0d got=%0b/%0h want=1/21", c, slc_valid, slc_tag); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL lock_noready got=%0b want=0000", req_ready); end
      edge_step();
      if (c == 0) add_req(0, 8'h20);
    end
    slc_ready = 1'b1;
    drive();
    total++; if (slc_tag !== 8'h21 || req_ready !== 4'b0010) begin bad++; $display("FAIL lock_accept got=%0h/%0b want=21/0010", slc_tag, req_ready); end
    edge_step();
    drive();
    total++; if (slc_tag !== 8'h20 || req_ready !== 4'b0001) begin bad++; $display("FAIL lock_next got=%0h/%0b want=20/0001", slc_tag, req_ready); end
    edge_step();
    run_until_rsp(2, 20, "lock");
  endtask

  task automatic test_full();
    do_reset();
    lat = 1; rsp_ready = '0;
    for (int i = 0; i < 6; i++) add_req(0, 8'(8'h30 + i));
    for (int c = 0; c < MF; c++) begin
      drive();
      total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL full_fill c=%0d got=%0b want=1", c, req_ready[0]); end
      edge_step();
    end
    for (int c = 0; c < 2; c++) begin
      drive();
      total++; if (slc_valid !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL full_block got=%0b/%0b want=0/0000", slc_valid, req_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%0b want=1", busy); end
      edge_step();
    end
    rsp_ready = 4'b0001;
    drive();
    total++; if (req_ready !== 4'b0001 || slc_valid !== 1'b1) begin bad++; $display("FAIL full_popissue got=%0b/%0b want=0001/1", req_ready, slc_valid); end
    total++; if (rsp_valid !== 4'b0001 || rsp_tag !== 8'h30) begin bad++; $display("FAIL full_rsp got=%0b/%0h want=0001/30", rsp_valid, rsp_tag); end
    edge_step();
    rsp_ready = '0;
    drive();
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL full_still got=%0b want=0000", req_ready); end
    edge_step();
    rsp_ready = '1;
    run_until_rsp(6, 40, "full");
    for (int i = 0; i < rsp_log.size(); i++) begin
      total++; if (rsp_log[i].tag !== 8'(8'h30 + i)) begin bad++; $display("FAIL full_order got=%0h want=%0h", rsp_log[i].tag, 8'h30 + i); end
    end
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    lat = 1; rsp_ready = 4'b1110;
    add_req(0, 8'h40); add_req(3, 8'h43);
    cycles(2);
    for (int c = 0; c < 5; c++) begin
      drive();
      total++; if (so_ready !== 1'b0) begin bad++; $display("FAIL bp_out_ready got=%0b want=0", so_ready); end
      total++; if (rsp_valid !== 4'b0001 || rsp_tag !== 8'h40) begin bad++; $display("FAIL bp_rsp got=%0b/%0h want=0001/40", rsp_valid, rsp_tag); end
      edge_step();
    end
    rsp_ready = '1;
    drive();
    total++; if (so_ready !== 1'b1 || rsp_valid !== 4'b0001) begin bad++; $display("FAIL bp_release got=%0b/%0b want=1/0001", so_ready, rsp_valid); end
    edge_step();
    drive();
    total++; if (rsp_valid !== 4'b1000 || rsp_tag !== 8'h43) begin bad++; $display("FAIL bp_second got=%0b/%0h want=1000/43", rsp_valid, rsp_tag); end
    edge_step();
    total++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin bad++; $display("FAIL bp_grants got_n=%0d want=0,3", grant_log.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    lat = 20;
    add_req(0, 8'h50); add_req(1, 8'h51); add_req(2, 8'h52);
    cycles(3);
    add_req(1, 8'h54);
    flush = 1'b1;
    drive();
    total++; if (slc_flush !== 1'b1) begin bad++; $display("FAIL fl_slc_flush got=%0b want=1", slc_flush); end
    total++; if (slc_valid !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL fl_issue got=%0b/%0b want=0/0000", slc_valid, req_ready); end
    total++; if (so_ready !== 1'b1 || rsp_valid !== 4'b0) begin bad++; $display("FAIL fl_out got=%0b/%0b want=1/0000", so_ready, rsp_valid); end
    edge_step();
    flush = 1'b0;
    rq[1].delete();
    drive();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_busy got=%0b want=0", busy); end
    edge_step();
    stray = 1'b1;
    drive();
    total++; if (rsp_valid !== 4'b0 || so_ready !== 1'b1) begin bad++; $display("FAIL fl_stray got=%0b/%0b want=0000/1", rsp_valid, so_ready); end
    edge_step();
    stray = 1'b0;
    total++; if (rsp_log.size() != 0) begin bad++; $display("FAIL fl_no_rsp got=%0d want=0", rsp_log.size()); end
    clear_logs();
    lat = 1;
    add_req(0, 8'h60); add_req(3, 8'h63);
    run_until_rsp(2, 20, "fl");
    total++; if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 0) begin bad++; $display("FAIL fl_rr_kept got_n=%0d want=3,0", grant_log.size()); end
    if (rsp_log.size() == 2) begin
      total++; if (rsp_log[0].port != 3 || rsp_log[0].tag !== 8'h63 || rsp_log[1].port != 0 || rsp_log[1].tag !== 8'h60) begin
        bad++; $display("FAIL fl_route got=%0d/%0h,%0d/%0h want=3/63,0/60", rsp_log[0].port, rsp_log[0].tag, rsp_log[1].port, rsp_log[1].tag);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 5;
    add_req(1, 8'h71); add_req(2, 8'h72);
    cycles(2);
    drive();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_busy_before got=%0b want=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin bad++; $display("FAIL mr_async got=%0b/%0b want=0/0000", busy, rsp_valid); end
    sq.delete();
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    add_req(2, 8'h73);
    run_until_rsp(1, 20, "mr");
    if (rsp_log.size() == 1) begin
      total++; if (rsp_log[0].port != 2 || rsp_log[0].tag !== 8'h73) begin bad++; $display("FAIL mr_route got=%0d/%0h want=2/73", rsp_log[0].port, rsp_log[0].tag); end
    end
  endtask

  // Reference: ports served in cyclic order after the last grant; an offer
  // that was refused is repeated until taken; results return in issue order.
  task automatic test_random();
    int m_rr, m_hold, off, occ, hp, seq[NR];
    logic [TW-1:0] infl[$];
    logic [TW-1:0] otag;
    logic e_ordy, e_pop, e_sv, srdy;
    logic [NR-1:0] e_rv;
    do_reset();
    m_rr = 0; m_hold = -1;
    for (int p = 0; p < NR; p++) seq[p] = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 400) begin
        for (int p = 0; p < NR; p++) if ($urandom_range(0, 3) == 0 && rq[p].size() < 3) begin
          add_req(p, 8'((p << 6) | (seq[p] % 64)));
          seq[p]++;
        end
        slc_ready = ($urandom_range(0, 3) != 0);
        rsp_ready = 4'($urandom) | 4'($urandom);
        lat = $urandom_range(1, 4);
      end else begin
        slc_ready = 1'b1; rsp_ready = '1; lat = 1;
      end
      drive();
      off = -1;
      if (m_hold >= 0) off = m_hold;
      else for (int k = 0; k < NR; k++) if (off < 0 && rq[(m_rr + k) % NR].size() > 0) off = (m_rr + k) % NR;
      occ = infl.size();
      hp = (occ > 0) ? int'(infl[0][7:6]) : 0;
      e_ordy = (occ == 0) ? 1'b1 : rsp_ready[hp];
      e_pop = so_valid && occ > 0 && e_ordy;
      e_sv = (off >= 0) && (occ < MF || e_pop);
      e_rv = '0;
      if (so_valid && occ > 0) e_rv[hp] = 1'b1;
      otag = (off >= 0) ? rq[off][0].tag : 8'h00;
      total++; if (slc_valid !== e_sv) begin bad++; $display("FAIL rnd_slc_valid c=%0d got=%0b want=%0b", c, slc_valid, e_sv); end
      total++; if (so_ready !== e_ordy) begin bad++; $display("FAIL rnd_out_ready c=%0d got=%0b want=%0b", c, so_ready, e_ordy); end
      total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%0b want=%0b", c, rsp_valid, e_rv); end
      total++; if (busy !== (occ > 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, busy, occ > 0); end
      if (e_sv) begin
        total++; if (slc_tag !== otag) begin bad++; $display("FAIL rnd_slc_tag c=%0d got=%0h want=%0h", c, slc_tag, otag); end
      end
      if (so_valid && occ > 0) begin
        total++; if (rsp_tag !== infl[0] || rsp_result !== exp_res[infl[0]]) begin
          bad++; $display("FAIL rnd_rsp_data c=%0d got=%0h/%0h want=%0h/%0h", c, rsp_tag, rsp_result, infl[0], exp_res[infl[0]]);
        end
      end
      srdy = slc_ready;
      edge_step();
      if (e_sv && srdy) begin
        infl.push_back(otag);
        m_rr = (off + 1) % NR;
        m_hold = -1;
      end else if (e_sv) m_hold = off;
      if (e_pop) void'(infl.pop_front());
    end
    total++; if (infl.size() != 0 || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0) begin
      bad++; $display("FAIL rnd_drain got=%0d inflight want=0", infl.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; slc_ready = 1'b0; rsp_ready = '1;
    req_valid = '0; req_operands = '0; req_tag = '0;
    for (int p = 0; p < NR; p++) begin
      req_op[p]  = fpnew_pkg::FMADD;
      req_rnd[p] = fpnew_pkg::RNE;
    end
    so_valid = 1'b0; so_result = '0; so_tag = '0; so_status = '0;
    @(negedge clk);
    test_reset();
    test_single_port();
    test_fairness();
    test_lock();
    test_full();
    test_rsp_backpressure();
    test_flush();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
